// File: rtl/game_pkg.sv
// Shared definitions for the game controller: direction codes, FSM states,
// board geometry and the cell-extract helper.
package game_pkg;

    localparam int CELL_W  = 4;
    localparam int N_CELLS = 16;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [3:0] {
        ST_INIT    = 4'd0,
        ST_IDLE    = 4'd1,
        ST_MOVE    = 4'd2,
        ST_SETTLE  = 4'd3,
        ST_COMPARE = 4'd4,
        ST_SEARCH  = 4'd5,
        ST_WRITE   = 4'd6,
        ST_CHECK   = 4'd7
    } state_t;

    function automatic logic [CELL_W-1:0] cell_at(input logic [CELL_W*N_CELLS-1:0] board,
                                                  input logic [3:0] idx);
        return board[{idx, 2'b00} +: CELL_W];
    endfunction

endpackage

// File: rtl/board_status.sv
// Combinational board summary: any empty cell, any mergeable orthogonal pair,
// and any cell holding the win code.
module board_status
    import game_pkg::*;
#(
    parameter logic [3:0] WIN_CODE = 4'd11
) (
    input  logic [63:0] board_state,
    output logic        has_empty,
    output logic        has_merge,
    output logic        has_win
);

    always_comb begin
        has_empty = 1'b0;
        has_merge = 1'b0;
        has_win   = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (cell_at(board_state, i[3:0]) == 4'd0)
                has_empty = 1'b1;
            if (cell_at(board_state, i[3:0]) == WIN_CODE)
                has_win = 1'b1;
            // Horizontal pairs must not wrap from column 3 into the next row.
            if ((i % 4) != 3 && cell_at(board_state, i[3:0]) == cell_at(board_state, 4'(i + 1)))
                has_merge = 1'b1;
            if (i < 12 && cell_at(board_state, i[3:0]) == cell_at(board_state, 4'(i + 4)))
                has_merge = 1'b1;
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Game-level move controller driving the tile board's shift enables and spawn port.
// Optional MOVE_COUNT_EN adds a saturating 16-bit move_count output.
module move_sequencer
    import game_pkg::*;
#(
    parameter int          MOVE_CYCLES   = 8,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [3:0]  WIN_CODE      = 4'd11
) (
    input  logic        clk,
    input  logic        rst,
    // Command handshake: a direction is taken on a cycle where dir_valid and
    // dir_ready are both high; dir_ready is only ever high in IDLE.
    input  logic        dir_valid,
    input  logic [1:0]  dir,
    output logic        dir_ready,
    input  logic [63:0] board_state,
    output logic [3:0]  ready_to_board,
    output logic        preset_ext,
    output logic [3:0]  preset_location,
    output logic [3:0]  value_from_preset,
    output logic        moved,
    output logic        win,
    output logic        game_over,
`ifdef MOVE_COUNT_EN
    output logic [15:0] move_count,
`endif
    output logic [3:0]  dbg_state
);

    state_t       r_state;
    logic [63:0]  r_snap;
    logic [7:0]   r_cnt;
    logic [3:0]   r_idx;
    logic [3:0]   r_scan;
    logic [1:0]   r_spawns;
    logic [15:0]  r_lfsr;

    logic         w_fb;
    logic         w_has_empty;
    logic         w_has_merge;
    logic         w_has_win;
    logic         w_dead;

    board_status #(.WIN_CODE(WIN_CODE)) u_status (
        .board_state (board_state),
        .has_empty   (w_has_empty),
        .has_merge   (w_has_merge),
        .has_win     (w_has_win)
    );

    assign w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_dead    = !w_has_empty && !w_has_merge;
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= ST_INIT;
            r_snap            <= '0;
            r_cnt             <= '0;
            r_idx             <= '0;
            r_scan            <= '0;
            r_spawns          <= '0;
            r_lfsr            <= LFSR_SEED;
            dir_ready         <= 1'b0;
            ready_to_board    <= '0;
            preset_ext        <= 1'b0;
            preset_location   <= '0;
            value_from_preset <= '0;
            moved             <= 1'b0;
            win               <= 1'b0;
            game_over         <= 1'b0;
        end else begin
            r_lfsr     <= {r_lfsr[14:0], w_fb};
            moved      <= 1'b0;
            preset_ext <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_spawns <= 2'd2;
                    r_idx    <= r_lfsr[3:0];
                    r_scan   <= '0;
                    r_state  <= ST_SEARCH;
                end
                ST_IDLE: begin
                    if (dir_valid && dir_ready) begin
                        r_snap         <= board_state;
                        ready_to_board <= 4'b0001 << dir;
                        dir_ready      <= 1'b0;
                        r_cnt          <= 8'(MOVE_CYCLES - 1);
                        r_state        <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (r_cnt == 8'd0) begin
                        ready_to_board <= '0;
                        r_cnt          <= 8'(SETTLE_CYCLES - 1);
                        r_state        <= ST_SETTLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 8'd0)
                        r_state <= ST_COMPARE;
                    else
                        r_cnt <= r_cnt - 8'd1;
                end
                ST_COMPARE: begin
                    if (board_state != r_snap) begin
                        moved   <= 1'b1;
                        r_idx   <= r_lfsr[3:0];
                        r_scan  <= '0;
                        r_state <= ST_SEARCH;
                    end else begin
                        dir_ready <= !game_over;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_SEARCH: begin
                    if (cell_at(board_state, r_idx) == 4'd0) begin
                        preset_ext        <= 1'b1;
                        preset_location   <= r_idx;
                        value_from_preset <= (r_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
                        r_state           <= ST_WRITE;
                    end else if (r_scan == 4'd15) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_idx  <= r_idx + 4'd1;
                        r_scan <= r_scan + 4'd1;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_has_win)
                        win <= 1'b1;
                    if (w_dead)
                        game_over <= 1'b1;
                    // INIT spawns twice; the first CHECK of that pair loops back to SEARCH.
                    if (r_spawns == 2'd2) begin
                        r_spawns <= 2'd1;
                        r_idx    <= r_lfsr[3:0];
                        r_scan   <= '0;
                        r_state  <= ST_SEARCH;
                    end else begin
                        r_spawns  <= 2'd0;
                        dir_ready <= !(game_over || w_dead);
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

`ifdef MOVE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            move_count <= '0;
        else if (moved && move_count != 16'hFFFF)
            move_count <= move_count + 16'd1;
    end
`endif

endmodule
